// File: rtl/rfg_ram_if_pkg.sv
// -----------------------------------------------------------------------------
// rfg_ram_if_pkg
// Shared definitions for the register-file RAM access front-end:
//   - state_e      : software access FSM states (IDLE, RD_WAIT, DONE)
//   - CNT_W        : width of the read-latency down-counter
//   - rd_latency() : RAM macro read latency for a given PIPELINED setting
// -----------------------------------------------------------------------------
package rfg_ram_if_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Wide enough to hold the largest read latency (2).
  localparam int unsigned CNT_W = 2;

  // The macro returns read data one cycle after the request, or two when its
  // output register is enabled.
  function automatic int unsigned rd_latency(input int unsigned pipelined);
    return (pipelined != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/rfg_valid_pipe.sv
// -----------------------------------------------------------------------------
// rfg_valid_pipe
// Fixed-depth delay line. d_i appears on q_o DEPTH cycles later.
//   clk      : clock
//   clr_n_i  : synchronous active-low clear of every stage
//   d_i      : WIDTH-bit input
//   q_o      : WIDTH-bit output, delayed by DEPTH cycles (registered)
// -----------------------------------------------------------------------------
module rfg_valid_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: non-blocking assignments so each stage samples its neighbour's
  // pre-edge value; blocking here would collapse the pipe into one stage.
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      // NOTE: every stage is cleared, not just the head, so nothing that was
      // in flight before the clear can surface afterwards.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rfg_ram_if.sv
// -----------------------------------------------------------------------------
// rfg_ram_if
// Access front-end for a 1-write/2-read register-file RAM macro.
//   Software side : sw_addr/sw_wen/sw_ren/sw_wdata in; sw_rdata,
//                   sw_access_complete, sw_invalid_address out (registered).
//                   Accesses are serialised onto the RAM write port and read
//                   port 1; requests outside IDLE are dropped.
//   Hardware side : hw_ren/hw_raddr in; hw_rdata, hw_rvalid out. Streams on
//                   RAM read port 2, never stalled, hw_rvalid aligned to the
//                   macro read latency.
//   RAM side      : ram_wen/ram_waddr/ram_wdata, ram_ren1/ram_raddr1,
//                   ram_ren2/ram_raddr2 out; ram_rdata1/ram_rdata2 in.
//   clk / res_n   : single clock, synchronous active-low reset.
// Build option RFG_RAM_IF_BYPASS_EN: forwards a same-cycle software write to a
// colliding hardware read instead of the macro's old data.
// -----------------------------------------------------------------------------
module rfg_ram_if
  import rfg_ram_if_pkg::*;
#(
  parameter int unsigned DATASIZE  = 18,
  parameter int unsigned ADDRSIZE  = 8,
  parameter int unsigned PIPELINED = 0
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [ADDRSIZE-1:0] sw_addr,
  input  logic                sw_wen,
  input  logic                sw_ren,
  input  logic [DATASIZE-1:0] sw_wdata,
  output logic [DATASIZE-1:0] sw_rdata,
  output logic                sw_access_complete,
  output logic                sw_invalid_address,
  input  logic                hw_ren,
  input  logic [ADDRSIZE-1:0] hw_raddr,
  output logic [DATASIZE-1:0] hw_rdata,
  output logic                hw_rvalid,
  output logic                ram_wen,
  output logic [ADDRSIZE-1:0] ram_waddr,
  output logic [DATASIZE-1:0] ram_wdata,
  output logic                ram_ren1,
  output logic [ADDRSIZE-1:0] ram_raddr1,
  input  logic [DATASIZE-1:0] ram_rdata1,
  output logic                ram_ren2,
  output logic [ADDRSIZE-1:0] ram_raddr2,
  input  logic [DATASIZE-1:0] ram_rdata2
);

  localparam int unsigned     LAT     = rd_latency(PIPELINED);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATASIZE-1:0]   sw_rdata_q;
  logic                  complete_q;
  logic                  invalid_q;

  logic idle, wr_req, rd_req, bad_req;

  // Gating with res_n keeps a request presented during reset from touching
  // the RAM while the FSM is being forced back to IDLE.
  assign idle    = res_n && (state_q == IDLE);
  assign wr_req  = idle && sw_wen && !sw_ren;
  assign rd_req  = idle && sw_ren && !sw_wen;
  assign bad_req = idle && sw_wen && sw_ren;

  // Software RAM strobes are issued in the request cycle itself.
  assign ram_wen    = wr_req;
  assign ram_waddr  = sw_addr;
  assign ram_wdata  = sw_wdata;
  assign ram_ren1   = rd_req;
  assign ram_raddr1 = sw_addr;

  // Hardware channel is a straight pass-through to read port 2.
  assign ram_ren2   = hw_ren;
  assign ram_raddr2 = hw_raddr;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sw_rdata_q <= '0;
      complete_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_req || bad_req) begin
            state_q    <= DONE;
            complete_q <= 1'b1;
            invalid_q  <= bad_req;
          end else if (rd_req) begin
            state_q <= RD_WAIT;
            cnt_q   <= LAT_CNT;
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Count of 1 marks the cycle the macro presents the read data.
          if (cnt_q == CNT_W'(1)) begin
            sw_rdata_q <= ram_rdata1;
            state_q    <= DONE;
            complete_q <= 1'b1;
            invalid_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          complete_q <= 1'b0;
          invalid_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_rdata           = sw_rdata_q;
  assign sw_access_complete = complete_q;
  assign sw_invalid_address = invalid_q;

  rfg_valid_pipe #(
    .DEPTH(LAT),
    .WIDTH(1)
  ) u_rvalid_pipe (
    .clk     (clk),
    .clr_n_i (res_n),
    .d_i     (hw_ren),
    .q_o     (hw_rvalid)
  );

`ifdef RFG_RAM_IF_BYPASS_EN
  // The macro returns old data when written and read at the same address in
  // one cycle; carry the write data alongside the read and substitute it.
  logic                byp_hit;
  logic [DATASIZE:0]   byp_q;

  assign byp_hit = ram_wen && hw_ren && (ram_waddr == hw_raddr);

  rfg_valid_pipe #(
    .DEPTH(LAT),
    .WIDTH(DATASIZE + 1)
  ) u_bypass_pipe (
    .clk     (clk),
    .clr_n_i (res_n),
    .d_i     ({byp_hit, ram_wdata}),
    .q_o     (byp_q)
  );

  assign hw_rdata = byp_q[DATASIZE] ? byp_q[DATASIZE-1:0] : ram_rdata2;
`else
  assign hw_rdata = ram_rdata2;
`endif

endmodule

// File: tb/tb_rfg_ram_if.sv
// -----------------------------------------------------------------------------
// tb_rfg_ram_if
// Drives two rfg_ram_if instances (PIPELINED=0 and PIPELINED=1) with identical
// stimulus, each attached to its own behavioural 1W2R RAM. A transaction-level
// reference model (shadow memory, busy-until cycle, expected completion and
// hardware-read schedule) predicts every output.
// -----------------------------------------------------------------------------
module tb_rfg_ram_if;

  localparam int DW = 18;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          res_n;
  logic          mem_clr;
  logic [AW-1:0] sw_addr;
  logic          sw_wen;
  logic          sw_ren;
  logic [DW-1:0] sw_wdata;
  logic          hw_ren;
  logic [AW-1:0] hw_raddr;

  logic [1:0][DW-1:0] sw_rdata, hw_rdata, ram_wdata, ram_rdata1, ram_rdata2;
  logic [1:0][AW-1:0] ram_waddr, ram_raddr1, ram_raddr2;
  logic [1:0]         sw_cmp, sw_inv, hw_rvalid, ram_wen, ram_ren1, ram_ren2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUTs, each with a behavioural RAM: writes and reads sample pre-edge memory,
  // so a same-cycle write/read collision returns old data.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [256];
    logic [DW-1:0] r1_s0, r1_s1, r2_s0, r2_s1;

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int a = 0; a < 256; a++) mem[a] <= '0;
        r1_s0 <= '0; r1_s1 <= '0; r2_s0 <= '0; r2_s1 <= '0;
      end else begin
        if (ram_wen[g]) mem[ram_waddr[g]] <= ram_wdata[g];
        if (ram_ren1[g]) r1_s0 <= mem[ram_raddr1[g]];
        if (ram_ren2[g]) r2_s0 <= mem[ram_raddr2[g]];
        r1_s1 <= r1_s0;
        r2_s1 <= r2_s0;
      end
    end

    assign ram_rdata1[g] = (g == 0) ? r1_s0 : r1_s1;
    assign ram_rdata2[g] = (g == 0) ? r2_s0 : r2_s1;

    rfg_ram_if #(
      .DATASIZE (DW),
      .ADDRSIZE (AW),
      .PIPELINED(g)
    ) u_dut (
      .clk                (clk),
      .res_n              (res_n),
      .sw_addr            (sw_addr),
      .sw_wen             (sw_wen),
      .sw_ren             (sw_ren),
      .sw_wdata           (sw_wdata),
      .sw_rdata           (sw_rdata[g]),
      .sw_access_complete (sw_cmp[g]),
      .sw_invalid_address (sw_inv[g]),
      .hw_ren             (hw_ren),
      .hw_raddr           (hw_raddr),
      .hw_rdata           (hw_rdata[g]),
      .hw_rvalid          (hw_rvalid[g]),
      .ram_wen            (ram_wen[g]),
      .ram_waddr          (ram_waddr[g]),
      .ram_wdata          (ram_wdata[g]),
      .ram_ren1           (ram_ren1[g]),
      .ram_raddr1         (ram_raddr1[g]),
      .ram_rdata1         (ram_rdata1[g]),
      .ram_ren2           (ram_ren2[g]),
      .ram_raddr2         (ram_raddr2[g]),
      .ram_rdata2         (ram_rdata2[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model. Edge e samples the inputs of cycle e; outputs seen after
  // edge e belong to cycle e+1. Index k is the instance, latency k+1.
  // ---------------------------------------------------------------------------
  int            n_edge = 0;
  bit            model_on = 1'b0;
  logic [DW-1:0] shadow    [2][256];
  int            free_cyc  [2];
  bit            pend_v    [2];
  int            pend_due  [2];
  bit            pend_inv  [2];
  bit            pend_rd   [2];
  logic [DW-1:0] pend_data [2];
  logic [DW-1:0] exp_rdata [2];
  bit            exp_hw_v  [2][8];
  logic [DW-1:0] exp_hw_d  [2][8];

  initial begin
    int e, lat;
    bit acc, wr, rd, bad;
    logic [DW-1:0] d;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) shadow[k][a] = '0;
      for (int s = 0; s < 8; s++) exp_hw_v[k][s] = 1'b0;
      free_cyc[k] = 0; pend_v[k] = 1'b0; exp_rdata[k] = '0;
    end
    forever begin
      @(posedge clk);
      n_edge++;
      e = n_edge;
      if (!res_n) begin
        model_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
          free_cyc[k]  = e + 1;
          pend_v[k]    = 1'b0;
          exp_rdata[k] = '0;
          for (int s = 0; s < 8; s++) exp_hw_v[k][s] = 1'b0;
        end
      end else if (model_on) begin
        for (int k = 0; k < 2; k++) begin
          lat = k + 1;
          acc = (e >= free_cyc[k]);
          wr  = acc && sw_wen && !sw_ren;
          rd  = acc && sw_ren && !sw_wen;
          bad = acc && sw_wen && sw_ren;
          if (hw_ren) begin
            d = shadow[k][hw_raddr];
`ifdef RFG_RAM_IF_BYPASS_EN
            if (wr && (sw_addr == hw_raddr)) d = sw_wdata;
`endif
            exp_hw_v[k][(e + lat) % 8] = 1'b1;
            exp_hw_d[k][(e + lat) % 8] = d;
          end
          if (wr) begin
            shadow[k][sw_addr] = sw_wdata;
            pend_v[k] = 1'b1; pend_due[k] = e + 1; pend_inv[k] = 1'b0; pend_rd[k] = 1'b0;
            free_cyc[k] = e + 2;
          end else if (rd) begin
            pend_v[k] = 1'b1; pend_due[k] = e + lat + 1; pend_inv[k] = 1'b0; pend_rd[k] = 1'b1;
            pend_data[k] = shadow[k][sw_addr];
            free_cyc[k] = e + lat + 2;
          end else if (bad) begin
            pend_v[k] = 1'b1; pend_due[k] = e + 1; pend_inv[k] = 1'b1; pend_rd[k] = 1'b0;
            free_cyc[k] = e + 2;
          end
        end
      end
    end
  end

  // Output comparison on the falling edge, away from the sampling edge.
  initial begin
    int cur;
    bit acc, exp_wen, exp_ren, due_now;
    string sfx;
    forever begin
      @(negedge clk);
      if (model_on) begin
        cur = n_edge + 1;
        for (int k = 0; k < 2; k++) begin
          sfx     = $sformatf("[L%0d]", k + 1);
          acc     = res_n && (cur >= free_cyc[k]);
          exp_wen = acc && sw_wen && !sw_ren;
          exp_ren = acc && sw_ren && !sw_wen;
          check({"ram_wen", sfx}, 32'(ram_wen[k]), 32'(exp_wen));
          if (exp_wen) begin
            check({"ram_waddr", sfx}, 32'(ram_waddr[k]), 32'(sw_addr));
            check({"ram_wdata", sfx}, 32'(ram_wdata[k]), 32'(sw_wdata));
          end
          check({"ram_ren1", sfx}, 32'(ram_ren1[k]), 32'(exp_ren));
          if (exp_ren) check({"ram_raddr1", sfx}, 32'(ram_raddr1[k]), 32'(sw_addr));
          check({"ram_ren2", sfx}, 32'(ram_ren2[k]), 32'(hw_ren));
          if (hw_ren) check({"ram_raddr2", sfx}, 32'(ram_raddr2[k]), 32'(hw_raddr));

          due_now = pend_v[k] && (pend_due[k] == cur);
          check({"sw_complete", sfx}, 32'(sw_cmp[k]), 32'(due_now));
          if (due_now) begin
            check({"sw_invalid", sfx}, 32'(sw_inv[k]), 32'(pend_inv[k]));
            if (pend_rd[k]) exp_rdata[k] = pend_data[k];
            pend_v[k] = 1'b0;
          end
          check({"sw_rdata", sfx}, 32'(sw_rdata[k]), 32'(exp_rdata[k]));

          check({"hw_rvalid", sfx}, 32'(hw_rvalid[k]), 32'(exp_hw_v[k][cur % 8]));
          if (exp_hw_v[k][cur % 8])
            check({"hw_rdata", sfx}, 32'(hw_rdata[k]), 32'(exp_hw_d[k][cur % 8]));
          exp_hw_v[k][cur % 8] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    sw_wen = 1'b0; sw_ren = 1'b0; sw_addr = '0; sw_wdata = '0;
    hw_ren = 1'b0; hw_raddr = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    sw_wen   = ($urandom_range(0, 3) == 0);
    sw_ren   = ($urandom_range(0, 3) == 0);
    sw_addr  = AW'($urandom_range(0, 15));
    sw_wdata = DW'($urandom);
    hw_ren   = ($urandom_range(0, 1) == 0);
    hw_raddr = AW'($urandom_range(0, 15));
  endtask

  // One-cycle software request, then quiet long enough for both instances.
  task automatic sw_op(input bit wen, input bit ren, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    sw_wen = wen; sw_ren = ren; sw_addr = addr; sw_wdata = data;
    step(1);
    drive_idle();
    step(6);
  endtask

  localparam logic [DW-1:0] COLL_OLD = 18'h11111;
  localparam logic [DW-1:0] COLL_NEW = 18'h22222;
`ifdef RFG_RAM_IF_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = COLL_NEW;
`else
  localparam logic [DW-1:0] COLL_EXP = COLL_OLD;
`endif

  initial begin
    int cnt0, cnt1;
    drive_idle();
    res_n   = 1'b0;
    mem_clr = 1'b1;
    step(1);
    mem_clr = 1'b0;

    // Reset held with random stimulus.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step(1);
    end
    for (int k = 0; k < 2; k++) begin
      check("rst sw_rdata",    32'(sw_rdata[k]),  32'h0);
      check("rst sw_complete", 32'(sw_cmp[k]),    32'h0);
      check("rst sw_invalid",  32'(sw_inv[k]),    32'h0);
      check("rst hw_rvalid",   32'(hw_rvalid[k]), 32'h0);
    end
    drive_idle();
    res_n = 1'b1;
    #1;
    check("post-rst ram_wen", 32'(ram_wen), 32'h0);
    step(2);

    // Write then read back.
    sw_op(1'b1, 1'b0, 8'h10, 18'h2A5B5);
    sw_op(1'b0, 1'b1, 8'h10, '0);
    check("wr/rd sw_rdata L1", 32'(sw_rdata[0]), 32'h2A5B5);
    check("wr/rd sw_rdata L2", 32'(sw_rdata[1]), 32'h2A5B5);

    // Read with a second request landing in RD_WAIT.
    sw_ren = 1'b1; sw_addr = 8'h10;
    step(1);
    sw_addr = 8'h11;
    step(1);
    drive_idle();
    step(6);

    // Simultaneous write and read: flagged invalid, no RAM access.
    sw_op(1'b1, 1'b1, 8'h05, 18'h3FFFF);

    // Reset during an outstanding read: no completion afterwards.
    sw_ren = 1'b1; sw_addr = 8'h10;
    step(1);
    drive_idle();
    res_n = 1'b0;
    step(1);
    res_n = 1'b1;
    step(6);

    // Hardware streaming over four preloaded words.
    for (int a = 0; a < 4; a++) sw_op(1'b1, 1'b0, AW'(a), DW'(18'h100 + a));
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      hw_ren   = (i < 4);
      hw_raddr = AW'(i);
      step(1);
      cnt0 += int'(hw_rvalid[0]);
      cnt1 += int'(hw_rvalid[1]);
    end
    drive_idle();
    check("stream count L1", 32'(cnt0), 32'd4);
    check("stream count L2", 32'(cnt1), 32'd4);

    // Write/read collision at one address.
    sw_op(1'b1, 1'b0, 8'h20, COLL_OLD);
    sw_wen = 1'b1; sw_addr = 8'h20; sw_wdata = COLL_NEW;
    hw_ren = 1'b1; hw_raddr = 8'h20;
    step(1);
    drive_idle();
    check("collision rvalid L1", 32'(hw_rvalid[0]), 32'h1);
    check("collision data L1",   32'(hw_rdata[0]),  32'(COLL_EXP));
    step(1);
    check("collision rvalid L2", 32'(hw_rvalid[1]), 32'h1);
    check("collision data L2",   32'(hw_rdata[1]),  32'(COLL_EXP));
    step(6);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      res_n = ($urandom_range(0, 299) != 0);
      rand_inputs();
      step(1);
    end

    drive_idle();
    res_n = 1'b1;
    step(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rfg_ram_if.md
Name: rfg_ram_if

Overview:
- Access front-end placed directly upstream of the 1-write/2-read register-file RAM macro.
- Serialises software register-file accesses (write + read) onto the RAM write port and read port 1.
- Exposes a hardware read channel on RAM read port 2, with a valid strobe aligned to the macro's read latency.
- Optional write-to-read bypass hides the macro's old-data-on-collision behaviour.

Parameters:
- DATASIZE, 18, RAM word width.
- ADDRSIZE, 8, RAM address width (depth 2**ADDRSIZE).
- PIPELINED, 0, must match the RAM instance. Read latency L = 1 when 0, L = 2 when 1.

Ports:
- clk  in  1  single clock.
- res_n  in  1  synchronous, active-low reset.
- sw_addr  in  ADDRSIZE  software access address.
- sw_wen  in  1  software write request (single-cycle strobe).
- sw_ren  in  1  software read request (single-cycle strobe).
- sw_wdata  in  DATASIZE  software write data.
- sw_rdata  out  DATASIZE  software read data, registered.
- sw_access_complete  out  1  one-cycle completion pulse.
- sw_invalid_address  out  1  error qualifier, valid with sw_access_complete.
- hw_ren  in  1  hardware read request.
- hw_raddr  in  ADDRSIZE  hardware read address.
- hw_rdata  out  DATASIZE  hardware read data.
- hw_rvalid  out  1  hw_rdata valid strobe.
- ram_wen, ram_waddr, ram_wdata  out  1/ADDRSIZE/DATASIZE  RAM write port.
- ram_ren1, ram_raddr1  out  1/ADDRSIZE  RAM read port 1.
- ram_rdata1  in  DATASIZE  RAM read port 1 data.
- ram_ren2, ram_raddr2  out  1/ADDRSIZE  RAM read port 2.
- ram_rdata2  in  DATASIZE  RAM read port 2 data.

Behaviour:
- Reset: while res_n=0 at a clk edge, the FSM goes to IDLE and the valid pipe is cleared. All registered outputs reset to 0: sw_rdata, sw_access_complete, sw_invalid_address, hw_rvalid.
- FSM states: IDLE, RD_WAIT, DONE.
- Requests are sampled only in IDLE. Requests arriving in any other state are dropped silently.
- IDLE, sw_wen & !sw_ren:
  - ram_wen=1 with ram_waddr=sw_addr and ram_wdata=sw_wdata in the same cycle (combinational).
  - Next state DONE with invalid=0.
  - Write completes 1 cycle after the request.
- IDLE, sw_ren & !sw_wen:
  - ram_ren1=1 with ram_raddr1=sw_addr in the same cycle.
  - A down-counter is loaded with L; next state RD_WAIT.
- IDLE, sw_ren & sw_wen: no RAM access; next state DONE with invalid=1.
- RD_WAIT:
  - The counter decrements each cycle.
  - On the cycle the counter reads 1, ram_rdata1 is captured into sw_rdata and the FSM goes to DONE.
  - Read completes L+1 cycles after the request cycle.
- DONE: sw_access_complete=1 for exactly one cycle, sw_invalid_address as latched; return to IDLE. sw_rdata holds its value until the next read.
- Hardware channel:
  - ram_ren2=hw_ren and ram_raddr2=hw_raddr, combinational and never stalled.
  - hw_rvalid = hw_ren delayed by L cycles.
  - hw_rdata = ram_rdata2 (pass-through); meaningful only while hw_rvalid=1.
  - Back-to-back reads are allowed: one result per cycle.
- Collision: software write and hardware read to the same address in the same cycle returns OLD data, unless the bypass feature is enabled.
- Reset mid-read: the FSM aborts and no completion pulse is issued. In-flight hw_rvalid bits are discarded.

Optional Feature:
- Macro: RFG_RAM_IF_BYPASS_EN.
- Defined:
  - When ram_wen & hw_ren & (ram_waddr==hw_raddr) in the same cycle, a hit flag and ram_wdata enter an L-deep pipe.
  - When the delayed hit flag is set, hw_rdata outputs the piped write data instead of ram_rdata2.
- Not defined: no compare logic and no data pipe; hw_rdata = ram_rdata2 always.

Decomposition:
- Package rfg_ram_if_pkg holds:
  - the FSM state typedef (IDLE, RD_WAIT, DONE);
  - the read-latency constant function rd_latency(PIPELINED);
  - the counter width constant (2 bits).
- Sub-module rfg_valid_pipe: parameterised-depth, parameterised-width delay line with synchronous active-low clear. It is used for hw_rvalid and for the bypass hit/data pipe.

Test Plan:
- Reset: hold res_n=0 for 3 cycles with random stimulus -> all outputs 0; ram_wen=0 after reset is released.
- SW write then read, PIPELINED=0: write 0x2A5B5 to addr 0x10 -> complete at +1. Then read addr 0x10 -> complete at +2 with sw_rdata=0x2A5B5 and invalid=0.
- SW read, PIPELINED=1: read addr 0x10 -> complete exactly at +3 with correct data. A second sw_ren issued in RD_WAIT is ignored (no extra RAM access, no extra complete pulse).
- Simultaneous sw_wen & sw_ren at addr 0x05 -> no ram_wen/ram_ren1; complete at +1 with invalid=1.
- HW streaming: hw_ren high for 4 cycles at addrs 0..3 preloaded with 0x100..0x103 -> hw_rvalid high for 4 consecutive cycles starting at +L, data in order.
- Collision: addr 0x20 holds 0x11111; same-cycle SW write 0x22222 and HW read of 0x20 -> hw_rdata=0x11111 without the macro, 0x22222 with RFG_RAM_IF_BYPASS_EN.
